sha256_block_loader: RTL and testbench
======================================

# sha256_block_loader

Upstream feeder for the SHA-256 hash core. Reads an NUM_OF_WORDS-word message from word-addressed memory, applies standard SHA-256 padding, and hands out 512-bit blocks one at a time over a valid/ready handshake. It replaces the core's internal message read and padding, so the core only consumes ready-made blocks.

## Interface
- NUM_OF_WORDS, 20, message length in 32-bit words; legal range 1..2047.
- clk  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on clk rising edge.
- start  in  1  begin loading; sampled only in IDLE.
- message_addr  in  16  word address of message word 0; latched on accepted start.
- mem_addr  out  16  read address to memory.
- mem_we  out  1  tied 0; block never writes.
- mem_read_data  in  32  memory data, valid one cycle after mem_addr.
- blk_valid  out  1  blk_data holds a complete block.
- blk_ready  in  1  consumer accepts block when high with blk_valid.
- blk_data  out  512  padded block; word 0 in [511:480], word 15 in [31:0].
- blk_last  out  1  qualifies blk_valid: final block of the message.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final block is accepted.

## Operation
- Block count NB = floor((N+2)/16)+1, where N = NUM_OF_WORDS. N=20 gives 2; N=13 gives 1; N=14 gives 2.
- Global slot g = 16*b + s, with block b in 0..NB-1 and slot s in 0..15. Slot content:
  - g < N: mem word at message_addr+g. Address is 16-bit and wraps modulo 2^16.
  - g == N: 32'h80000000.
  - b == NB-1 and s == 14: 32'h0, the high half of the 64-bit bit-length.
  - b == NB-1 and s == 15: N*32, 32-bit.
  - otherwise: 32'h0.
- States:
  - IDLE: start moves to READ; b=0, s=0, message_addr latched.
  - READ: one slot issued per cycle. For slot s, mem_addr = message_addr+g is driven in cycle s. Data is written into slot s of blk_data in cycle s+1. After slot 15 is written, go to HOLD.
  - HOLD: blk_valid=1. blk_valid && blk_ready with b<NB-1 increments b and returns to READ. The same handshake with b==NB-1 goes to IDLE and pulses done.
- Non-memory slots still take one READ cycle each, so every block costs exactly 17 READ cycles. mem_addr is don't-care-stable (held at the last address) for those slots.
- blk_data is stable throughout HOLD. Slots are overwritten only in the next READ.
- start is ignored while busy.

## Timing
- Reset values: mem_addr=0, mem_we=0, blk_valid=0, blk_last=0, blk_data=0, busy=0, done=0, state IDLE.
- Reset asserted in any state returns to IDLE on the next edge. Any partial block is discarded and no done pulse is issued.
- Start accepted in cycle T: mem_addr for g=0 in T+1, blk_valid first high in T+18.
- Each later block: READ starts the cycle after the handshake, blk_valid high 17 cycles later. Minimum 18 cycles per block.
- done rises the cycle after the final handshake, lasts 1 cycle, and coincides with busy=0. start may be accepted in that same cycle.
- blk_valid never drops without a handshake. blk_ready while blk_valid=0 has no effect.

## Structure
- Shared package sha256_pkg holds:
  - BLOCK_WORDS=16, PAD_WORD=32'h80000000.
  - Function num_blocks(N) = floor((N+2)/16)+1, also used by the hash core.
  - State enum type.
- One combinational sub-module, sha256_pad_slot. Inputs: g, b, s, N, NB, mem_read_data. Output: the 32-bit slot word.

## Test plan
- N=20, mem[i]=32'h01000000+i at message_addr=16'h0100:
  - block 0 = words 0..15.
  - block 1 = words 16..19, then 80000000, zeros, 0, 00000280, with blk_last=1.
  - done pulses once.
- N=13: single block. Slot 13 = 80000000, slot 14 = 0, slot 15 = 000001A0, blk_last=1.
- N=14: two blocks. Block 0 slots 14,15 = 80000000,0. Block 1 is all zero except slot 15 = 000001C0.
- Backpressure: blk_ready held low 10 cycles in HOLD. blk_valid and blk_data stay constant, mem_addr does not advance, and the handshake then proceeds normally.
- message_addr=16'hFFFE, N=20: addresses run FFFE, FFFF, 0000, ... and the data matches.
- Reset mid-READ of block 1, and start pulsed while busy: outputs return to reset values, and the extra start is ignored. A fresh start then reproduces the N=20 result exactly.

Source files
------------

// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 message feeder and hash core.
//   BLOCK_WORDS  : 32-bit words per 512-bit block
//   PAD_WORD     : the single '1' bit appended right after the message
//   state_t      : loader FSM state encoding
//   num_blocks() : padded block count for an N-word message
// -----------------------------------------------------------------------------
package sha256_pkg;

    localparam int          BLOCK_WORDS = 16;
    localparam logic [31:0] PAD_WORD    = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // The message, the pad word and the two length words must all fit, so
    // N+3 words are needed; this is ceil((N+3)/16) written without a divide
    // by a non-constant.
    function automatic int num_blocks(input int n);
        return (n + 2) / BLOCK_WORDS + 1;
    endfunction

endpackage

// File: rtl/sha256_block_loader_if.sv
// -----------------------------------------------------------------------------
// sha256_block_loader_if
// Bundles the memory read port and the block output handshake of the loader.
//   mem_addr      : word read address (loader -> memory)
//   mem_we        : write enable, always 0 (loader -> memory)
//   mem_read_data : read data, one cycle after mem_addr (memory -> loader)
//   blk_valid     : blk_data holds a complete padded block (loader -> consumer)
//   blk_ready     : consumer accepts the block (consumer -> loader)
//   blk_data      : 512-bit block, word 0 in [511:480] (loader -> consumer)
//   blk_last      : qualifies blk_valid, final block of the message
//
// Handshake: a block transfers on every rising edge where blk_valid and
// blk_ready are both high. Once raised, blk_valid stays high and blk_data and
// blk_last stay constant until that transfer. blk_ready may be raised or
// dropped at any time and has no effect while blk_valid is low.
// -----------------------------------------------------------------------------
interface sha256_block_loader_if;

    logic [15:0]  mem_addr;
    logic         mem_we;
    logic [31:0]  mem_read_data;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;

    modport master (
        output mem_addr,
        output mem_we,
        input  mem_read_data,
        output blk_valid,
        input  blk_ready,
        output blk_data,
        output blk_last
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        output mem_read_data,
        input  blk_valid,
        output blk_ready,
        input  blk_data,
        input  blk_last
    );

endinterface

// File: rtl/sha256_pad_slot.sv
// -----------------------------------------------------------------------------
// sha256_pad_slot
// Combinational selector for the content of one padded-message slot.
//   g_i             : global slot index, 16*b + s
//   b_i             : block index
//   s_i             : slot index inside the block (0..15)
//   n_i             : message length in words
//   nb_i            : number of blocks
//   mem_read_data_i : memory word read for this slot
//   slot_word_o     : final 32-bit slot content
// -----------------------------------------------------------------------------
module sha256_pad_slot
    import sha256_pkg::*;
(
    input  logic [15:0] g_i,
    input  logic [7:0]  b_i,
    input  logic [3:0]  s_i,
    input  logic [15:0] n_i,
    input  logic [7:0]  nb_i,
    input  logic [31:0] mem_read_data_i,
    output logic [31:0] slot_word_o
);

    logic last_blk;

    assign last_blk = (b_i == nb_i - 8'd1);

    // Slot 14 of the last block is the upper half of the 64-bit bit length,
    // which is always zero for N <= 2047, so it falls into the default.
    always_comb begin
        slot_word_o = 32'h0;
        if (g_i < n_i) begin
            slot_word_o = mem_read_data_i;
        end else if (g_i == n_i) begin
            slot_word_o = PAD_WORD;
        end else if (last_blk && (s_i == 4'd15)) begin
            slot_word_o = {11'b0, n_i, 5'b0};
        end
    end

endmodule

// File: rtl/sha256_block_loader.sv
// -----------------------------------------------------------------------------
// sha256_block_loader
// Reads an NUM_OF_WORDS-word message from word-addressed memory, applies
// SHA-256 padding and presents the padded message one 512-bit block at a time.
//   clk          : clock, rising edge
//   reset_n      : synchronous active-low reset
//   start        : begin loading, only looked at while idle
//   message_addr : word address of message word 0, latched on start
//   bus          : memory read port and block handshake (master side)
//   busy         : high whenever not idle
//   done         : one-cycle pulse after the final block is accepted
//   dbg_state_o  : current FSM state
//
// Every block spends 17 cycles in READ: cycle c issues the address of slot c
// (c = 0..15) and writes the data for slot c-1 (c = 1..16). Slots that do not
// come from memory still take their cycle, keeping block timing fixed.
// -----------------------------------------------------------------------------
module sha256_block_loader
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [15:0]           message_addr,
    sha256_block_loader_if.master bus,
    output logic                  busy,
    output logic                  done,
    output state_t                dbg_state_o
);

    localparam int          NB        = num_blocks(NUM_OF_WORDS);
    localparam logic [15:0] N16       = 16'(NUM_OF_WORDS);
    localparam logic [7:0]  NB8       = 8'(NB);
    localparam logic [7:0]  LAST_B    = 8'(NB - 1);
    localparam logic [4:0]  LAST_READ = 5'(BLOCK_WORDS);

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [7:0]         b_q, b_d;
    logic [15:0]        base_q, base_d;
    logic [15:0]        addr_q, addr_d;
    logic [15:0][31:0]  words_q, words_d;
    logic               done_q, done_d;

    logic [4:0]         cnt_m1;
    logic [3:0]         wr_slot;
    logic [15:0]        wr_g;
    logic [15:0]        nxt_g;
    logic [15:0]        nxt_blk_g;
    logic [31:0]        slot_word;

    // Data arriving in READ cycle c belongs to the address issued in c-1.
    assign cnt_m1    = cnt_q - 5'd1;
    assign wr_slot   = cnt_m1[3:0];
    assign wr_g      = {4'b0, b_q, wr_slot};
    assign nxt_g     = {4'b0, b_q, 4'b0} + {11'b0, cnt_q} + 16'd1;
    assign nxt_blk_g = {4'b0, b_q + 8'd1, 4'b0};

    sha256_pad_slot u_pad_slot (
        .g_i             (wr_g),
        .b_i             (b_q),
        .s_i             (wr_slot),
        .n_i             (N16),
        .nb_i            (NB8),
        .mem_read_data_i (bus.mem_read_data),
        .slot_word_o     (slot_word)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            b_q     <= 8'd0;
            base_q  <= 16'd0;
            addr_q  <= 16'd0;
            words_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        base_d  = base_q;
        addr_d  = addr_q;
        words_d = words_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    cnt_d   = 5'd0;
                    b_d     = 8'd0;
                    base_d  = message_addr;
                    // N >= 1, so slot 0 of block 0 is always a memory word.
                    addr_d  = message_addr;
                end
            end

            ST_READ: begin
                if (cnt_q != 5'd0) begin
                    // Slot s lives at word index 15-s of the packed array.
                    words_d[4'd15 - wr_slot] = slot_word;
                end
                // Only memory slots move the address; others keep it steady.
                if ((cnt_q < 5'd15) && (nxt_g < N16)) begin
                    addr_d = base_q + nxt_g;
                end
                if (cnt_q == LAST_READ) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            ST_HOLD: begin
                if (bus.blk_ready) begin
                    if (b_q == LAST_B) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        cnt_d   = 5'd0;
                        b_d     = b_q + 8'd1;
                        if (nxt_blk_g < N16) begin
                            addr_d = base_q + nxt_blk_g;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = 1'b0;
    assign bus.blk_valid = (state_q == ST_HOLD);
    assign bus.blk_data  = words_q;
    assign bus.blk_last  = (state_q == ST_HOLD) && (b_q == LAST_B);
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sha256_block_loader.sv
// -----------------------------------------------------------------------------
// tb_sha256_block_loader
// Three loader instances (N = 20, 13, 14) share one memory array. One of them
// is selected at a time; a negedge process compares the selected instance
// against a padding/timing model built from queues and cycle ages.
// -----------------------------------------------------------------------------
module tb_sha256_block_loader;
    import sha256_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        blk_ready;
    logic [15:0] message_addr;
    int          sel;

    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    state_t      dbg_a, dbg_b, dbg_c;

    logic [31:0] mem [0:65535];

    sha256_block_loader_if bus_a ();
    sha256_block_loader_if bus_b ();
    sha256_block_loader_if bus_c ();

    sha256_block_loader #(.NUM_OF_WORDS(20)) dut_a (
        .clk (clk), .reset_n (reset_n), .start (start && (sel == 0)),
        .message_addr (message_addr), .bus (bus_a),
        .busy (busy_a), .done (done_a), .dbg_state_o (dbg_a)
    );
    sha256_block_loader #(.NUM_OF_WORDS(13)) dut_b (
        .clk (clk), .reset_n (reset_n), .start (start && (sel == 1)),
        .message_addr (message_addr), .bus (bus_b),
        .busy (busy_b), .done (done_b), .dbg_state_o (dbg_b)
    );
    sha256_block_loader #(.NUM_OF_WORDS(14)) dut_c (
        .clk (clk), .reset_n (reset_n), .start (start && (sel == 2)),
        .message_addr (message_addr), .bus (bus_c),
        .busy (busy_c), .done (done_c), .dbg_state_o (dbg_c)
    );

    assign bus_a.blk_ready = blk_ready;
    assign bus_b.blk_ready = blk_ready;
    assign bus_c.blk_ready = blk_ready;

    always @(posedge clk) begin
        bus_a.mem_read_data <= mem[bus_a.mem_addr];
        bus_b.mem_read_data <= mem[bus_b.mem_addr];
        bus_c.mem_read_data <= mem[bus_c.mem_addr];
    end

    // ---------------- view of the selected instance ----------------
    logic         v_valid, v_last, v_busy, v_done, v_we;
    logic [15:0]  v_addr;
    logic [511:0] v_data;

    always_comb begin
        v_valid = bus_c.blk_valid; v_last = bus_c.blk_last; v_busy = busy_c;
        v_done  = done_c; v_we = bus_c.mem_we; v_addr = bus_c.mem_addr;
        v_data  = bus_c.blk_data;
        if (sel == 0) begin
            v_valid = bus_a.blk_valid; v_last = bus_a.blk_last; v_busy = busy_a;
            v_done  = done_a; v_we = bus_a.mem_we; v_addr = bus_a.mem_addr;
            v_data  = bus_a.blk_data;
        end else if (sel == 1) begin
            v_valid = bus_b.blk_valid; v_last = bus_b.blk_last; v_busy = busy_b;
            v_done  = done_b; v_we = bus_b.mem_we; v_addr = bus_b.mem_addr;
            v_data  = bus_b.blk_data;
        end
    end

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    // ---------------- scoreboard bookkeeping ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic         chk_en   = 1'b0;

    logic [31:0]  exp_q[$];
    int           exp_n  = 0;
    int           exp_nb = 0;

    logic         m_active = 1'b0;
    logic         m_done   = 1'b0;
    int           m_age    = 0;
    int           m_blk    = 0;
    logic [15:0]  m_base   = 16'h0;
    int           done_seen = 0;
    logic [511:0] cap_blk [0:3];
    logic [511:0] ref_blk [0:1];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk512(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Textbook padding: message, one '1' word, zeros up to 14 mod 16, 64-bit length.
    task automatic build_model(input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(32'h0100_0000 + 32'(i));
        exp_q.push_back(32'h8000_0000);
        while ((exp_q.size() % 16) != 14) exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'(n * 32));
        exp_n  = n;
        exp_nb = exp_q.size() / 16;
    endtask

    function automatic logic [511:0] exp_block(input int blk);
        logic [511:0] r;
        r = '0;
        for (int s = 0; s < 16; s++) r[(15 - s) * 32 +: 32] = exp_q[blk * 16 + s];
        return r;
    endfunction

    function automatic logic [31:0] slot_of(input logic [511:0] blk, input int s);
        return blk[(15 - s) * 32 +: 32];
    endfunction

    // Address left on the bus once a block is loaded: last memory slot so far.
    function automatic int last_mem_g(input int blk);
        int g;
        g = blk * 16 + 15;
        if (g > exp_n - 1) g = exp_n - 1;
        return g;
    endfunction

    task automatic fill_mem(input logic [15:0] base, input int n);
        for (int a = 0; a < 65536; a++) mem[a] = 32'hDEAD_0000 | 32'(a);
        for (int i = 0; i < n; i++) mem[16'(base + 16'(i))] = 32'h0100_0000 + 32'(i);
    endtask

    // ---------------- compare process ----------------
    initial begin
        logic e_valid;
        int   g;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (m_active) m_age++;
                e_valid = m_active && (m_age >= 18);
                chk1("blk_valid", v_valid, e_valid);
                chk1("busy", v_busy, m_active);
                chk1("done", v_done, m_done);
                chk1("mem_we", v_we, 1'b0);
                if (e_valid) begin
                    chk1("blk_last", v_last, m_blk == exp_nb - 1);
                    chk512("blk_data", v_data, exp_block(m_blk));
                    chk16("hold_addr", v_addr, m_base + 16'(last_mem_g(m_blk)));
                end else begin
                    chk1("blk_last_idle", v_last, 1'b0);
                end
                if (m_active && (m_age >= 1) && (m_age <= 16)) begin
                    g = m_blk * 16 + m_age - 1;
                    if (g < exp_n) chk16("mem_addr", v_addr, m_base + 16'(g));
                end
                if (v_done) done_seen++;

                m_done = 1'b0;
                if (!reset_n) begin
                    m_active = 1'b0;
                end else if (!m_active) begin
                    if (start) begin
                        m_active = 1'b1;
                        m_age    = 0;
                        m_blk    = 0;
                        m_base   = message_addr;
                    end
                end else if (e_valid && blk_ready) begin
                    cap_blk[m_blk] = v_data;
                    if (m_blk == exp_nb - 1) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end else begin
                        m_blk++;
                        m_age = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic setup(input int dut, input logic [15:0] base, input int n);
        sel = dut;
        fill_mem(base, n);
        build_model(n);
        done_seen = 0;
    endtask

    task automatic do_start(input logic [15:0] base);
        @(posedge clk); #1;
        message_addr = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic take_block(input int stall, output int lat);
        lat = 0;
        while (!v_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk1("valid_seen", v_valid, 1'b1);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        if (stall > 0) begin
            chk1("stall_valid", v_valid, 1'b1);
            chk512("stall_data", v_data, exp_block(m_blk));
            chk16("stall_addr", v_addr, m_base + 16'(last_mem_g(m_blk)));
        end
        blk_ready = 1'b1;
        @(posedge clk); #1;
        blk_ready = 1'b0;
    endtask

    task automatic end_run();
        chk1("done_pulse", v_done, 1'b1);
        chk1("done_not_busy", v_busy, 1'b0);
        @(posedge clk); #1;
        chk1("done_width", v_done, 1'b0);
        chk32("done_count", 32'(done_seen), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        reset_n      = 1'b0;
        start        = 1'b0;
        blk_ready    = 1'b0;
        message_addr = 16'h0;
        sel          = 0;
        fill_mem(16'h0100, 20);
        build_model(20);

        repeat (3) @(posedge clk);
        #1;
        chk1("rst_busy_a", busy_a, 1'b0);
        chk1("rst_busy_b", busy_b, 1'b0);
        chk1("rst_busy_c", busy_c, 1'b0);
        chk1("rst_valid_a", bus_a.blk_valid, 1'b0);
        chk1("rst_last_a", bus_a.blk_last, 1'b0);
        chk1("rst_done_a", done_a, 1'b0);
        chk16("rst_addr_a", bus_a.mem_addr, 16'h0);
        chk512("rst_data_a", bus_a.blk_data, 512'h0);
        chk32("rst_state_a", 32'(dbg_a), 32'(ST_IDLE));
        chk32("rst_state_b", 32'(dbg_b), 32'(ST_IDLE));
        chk32("rst_state_c", 32'(dbg_c), 32'(ST_IDLE));
        chk_en  = 1'b1;
        reset_n = 1'b1;

        // N=20 at 0x0100
        setup(0, 16'h0100, 20);
        chk32("model_len20", 32'(exp_q.size()), 32'd32);
        chk32("model_pad20", exp_q[20], 32'h8000_0000);
        chk32("model_len_word20", exp_q[31], 32'h0000_0280);
        do_start(16'h0100);
        chk16("first_addr", v_addr, 16'h0100);
        take_block(0, lat);
        chk32("latency_blk0", 32'(lat), 32'd17);
        take_block(0, lat);
        chk32("latency_blk1", 32'(lat), 32'd17);
        end_run();
        chk32("n20_b0_s0", slot_of(cap_blk[0], 0), 32'h0100_0000);
        chk32("n20_b0_s15", slot_of(cap_blk[0], 15), 32'h0100_000F);
        chk32("n20_b1_s3", slot_of(cap_blk[1], 3), 32'h0100_0013);
        chk32("n20_b1_s4", slot_of(cap_blk[1], 4), 32'h8000_0000);
        chk32("n20_b1_s14", slot_of(cap_blk[1], 14), 32'h0);
        chk32("n20_b1_s15", slot_of(cap_blk[1], 15), 32'h0000_0280);
        ref_blk[0] = cap_blk[0];
        ref_blk[1] = cap_blk[1];

        // N=13: one block
        setup(1, 16'h0040, 13);
        chk32("model_nb13", 32'(exp_nb), 32'd1);
        do_start(16'h0040);
        take_block(0, lat);
        chk32("latency_n13", 32'(lat), 32'd17);
        end_run();
        chk32("n13_s12", slot_of(cap_blk[0], 12), 32'h0100_000C);
        chk32("n13_s13", slot_of(cap_blk[0], 13), 32'h8000_0000);
        chk32("n13_s14", slot_of(cap_blk[0], 14), 32'h0);
        chk32("n13_s15", slot_of(cap_blk[0], 15), 32'h0000_01A0);

        // N=14: pad word fills block 0, length alone in block 1
        setup(2, 16'h0200, 14);
        chk32("model_nb14", 32'(exp_nb), 32'd2);
        do_start(16'h0200);
        take_block(0, lat);
        take_block(0, lat);
        end_run();
        chk32("n14_b0_s13", slot_of(cap_blk[0], 13), 32'h0100_000D);
        chk32("n14_b0_s14", slot_of(cap_blk[0], 14), 32'h8000_0000);
        chk32("n14_b0_s15", slot_of(cap_blk[0], 15), 32'h0);
        chk512("n14_b1", cap_blk[1], {480'h0, 32'h0000_01C0});

        // Backpressure: consumer waits 10 cycles on each block
        setup(0, 16'h0100, 20);
        do_start(16'h0100);
        take_block(10, lat);
        take_block(10, lat);
        end_run();
        chk512("bp_b0", cap_blk[0], ref_blk[0]);
        chk512("bp_b1", cap_blk[1], ref_blk[1]);

        // Address wrap from 0xFFFE
        setup(0, 16'hFFFE, 20);
        do_start(16'hFFFE);
        chk16("wrap_a0", v_addr, 16'hFFFE);
        @(posedge clk); #1;
        chk16("wrap_a1", v_addr, 16'hFFFF);
        @(posedge clk); #1;
        chk16("wrap_a2", v_addr, 16'h0000);
        take_block(0, lat);
        take_block(0, lat);
        end_run();
        chk32("wrap_b0_s2", slot_of(cap_blk[0], 2), 32'h0100_0002);
        chk32("wrap_b1_s3", slot_of(cap_blk[1], 3), 32'h0100_0013);

        // Reset in the middle of block 1, with a stray start while busy
        setup(0, 16'h0100, 20);
        do_start(16'h0100);
        take_block(0, lat);
        repeat (4) begin
            @(posedge clk); #1;
        end
        do_start(16'h0300);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk1("mid_rst_busy", v_busy, 1'b0);
        chk1("mid_rst_valid", v_valid, 1'b0);
        chk1("mid_rst_last", v_last, 1'b0);
        chk1("mid_rst_done", v_done, 1'b0);
        chk16("mid_rst_addr", v_addr, 16'h0);
        chk512("mid_rst_data", v_data, 512'h0);
        chk32("mid_rst_state", 32'(dbg_a), 32'(ST_IDLE));
        repeat (25) begin
            @(posedge clk); #1;
        end
        chk32("no_done_after_rst", 32'(done_seen), 32'd0);
        do_start(16'h0100);
        take_block(0, lat);
        take_block(0, lat);
        end_run();
        chk512("rerun_b0", cap_blk[0], ref_blk[0]);
        chk512("rerun_b1", cap_blk[1], ref_blk[1]);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
